// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_length;
  logic              req_sign;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_length, req_sign, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_length, req_sign, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, WAIT_CYCLES wait states, byte/half/word little-endian access.
// Response is valid WAIT_CYCLES+1 cycles after the accept cycle and is held stable until rsp_ready.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        len_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              lat_en, acc_en;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              idle;
  logic              acc_write, acc_sign, acc_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [1:0]        acc_len;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       rword, rshift, load_val, wlane;
  logic [3:0]        be;

  assign idle = (state_q == S_IDLE);

  // With zero wait states the access happens on the accept edge, so it must use the live request.
  assign acc_write = idle ? bus.req_write  : write_q;
  assign acc_sign  = idle ? bus.req_sign   : sign_q;
  assign acc_addr  = idle ? bus.req_addr   : addr_q;
  assign acc_wdata = idle ? bus.req_wdata  : wdata_q;
  assign acc_len   = idle ? bus.req_length : len_q;
  assign acc_idx   = IDX_W'(acc_addr[ADDR_W-1:2]);

  assign acc_err = (acc_len == 2'b11) ||
                   (acc_len == 2'b01 && acc_addr[0]) ||
                   (acc_len == 2'b10 && acc_addr[1:0] != 2'b00);

  assign rword  = mem_q[acc_idx];
  assign rshift = rword >> {acc_addr[1:0], 3'b000};

  always_comb begin
    load_val = rword;
    wlane    = acc_wdata;
    be       = 4'b1111;
    case (acc_len)
      2'b00: begin
        load_val = {{24{rshift[7] & acc_sign}}, rshift[7:0]};
        wlane    = {4{acc_wdata[7:0]}};
        be       = 4'b0001 << acc_addr[1:0];
      end
      2'b01: begin
        load_val = {{16{rshift[15] & acc_sign}}, rshift[15:0]};
        wlane    = {2{acc_wdata[15:0]}};
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    lat_en  = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          lat_en = 1'b1;
          if (WAIT_CYCLES == 0) begin
            acc_en  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          acc_en  = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (acc_en) begin
      rdata_d = (acc_err || acc_write) ? 32'd0 : load_val;
      err_d   = acc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      len_q   <= 2'b00;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (lat_en) begin
        write_q <= bus.req_write;
        sign_q  <= bus.req_sign;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        len_q   <= bus.req_length;
      end
    end
  end

  // Storage is deliberately not reset; the rst_n gate keeps a held request from writing during reset.
  always_ff @(posedge clk) begin
    if (rst_n && acc_en && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[acc_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = idle;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 3 and 0 wait states) share one stimulus bus selected by sel.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_sign = 1'b0, rsp_ready = 1'b0;
  logic [11:0] req_addr = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_length = 2'b00;
  logic        o_rdy, o_vld, o_err;
  logic [31:0] o_rdata;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mdl [3][4096];

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(12)) if0 ();
  dmem_responder_if #(.ADDR_W(12)) if1 ();
  dmem_responder_if #(.ADDR_W(12)) if2 ();

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.req_write = req_write;  assign if1.req_write = req_write;  assign if2.req_write = req_write;
  assign if0.req_addr = req_addr;    assign if1.req_addr = req_addr;    assign if2.req_addr = req_addr;
  assign if0.req_wdata = req_wdata;  assign if1.req_wdata = req_wdata;  assign if2.req_wdata = req_wdata;
  assign if0.req_length = req_length; assign if1.req_length = req_length; assign if2.req_length = req_length;
  assign if0.req_sign = req_sign;    assign if1.req_sign = req_sign;    assign if2.req_sign = req_sign;
  assign if0.rsp_ready = rsp_ready;  assign if1.rsp_ready = rsp_ready;  assign if2.rsp_ready = rsp_ready;

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(12), .WAIT_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(12), .WAIT_CYCLES(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(12), .WAIT_CYCLES(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  always_comb begin
    o_rdy = if0.req_ready; o_vld = if0.rsp_valid; o_rdata = if0.rsp_rdata; o_err = if0.rsp_err;
    if (sel == 1) begin
      o_rdy = if1.req_ready; o_vld = if1.rsp_valid; o_rdata = if1.rsp_rdata; o_err = if1.rsp_err;
    end else if (sel == 2) begin
      o_rdy = if2.req_ready; o_vld = if2.rsp_valid; o_rdata = if2.rsp_rdata; o_err = if2.rsp_err;
    end
  end

  function automatic int waits(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte-array memory, little-endian assembly, extension from the top byte of the access.
  task automatic model(input int d, input bit w, input int a, input logic [31:0] wd,
                       input int len, input bit sg, output logic [31:0] rd, output bit er);
    int n;
    n  = (len == 0) ? 1 : (len == 1) ? 2 : 4;
    er = (len == 3) || (a % n != 0);
    rd = 32'd0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[d][a+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = mdl[d][a+i];
        if (sg && rd[8*n-1]) for (int j = n; j < 4; j++) rd[8*j +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic do_req(input int d, input bit w, input logic [11:0] a, input logic [31:0] wd,
                        input logic [1:0] len, input bit sg, input int hold,
                        output logic [31:0] rd, output logic er);
    int n;
    int lat;
    bit stable;
    sel = d; req_write = w; req_addr = a; req_wdata = wd; req_length = len; req_sign = sg;
    req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!o_rdy && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_ready", {31'd0, o_rdy}, 32'd1);
    @(posedge clk); #1;
    // Scramble the request after accept: only the accept-edge values may matter.
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 12'($urandom);
    req_wdata = $urandom; req_length = 2'($urandom); req_sign = 1'($urandom);
    lat = 1;
    while (!o_vld && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, waits(d) + 1);
    rd = o_rdata; er = o_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!o_vld || o_rdy || o_rdata !== rd || o_err !== er) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("after_handshake", {30'd0, o_vld, o_rdy}, 32'd1);
  endtask

  typedef struct {
    bit          w;
    logic [11:0] a;
    logic [31:0] wd;
    logic [1:0]  len;
    bit          sg;
    int          hold;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, mrd;
    logic        er;
    bit          mer;
    logic [11:0] sa[4];
    logic [1:0]  sl[4];
    bit          ss[4];

    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, mrd;
    logic        er;
    bit          mer;
    logic [11:0] sa[4];
    logic [1:0]  sl[4];
    bit          ss[4];

    tbl.push_back('{1, 12'h010, 32'hDEADBEEF, 2'b10, 0, 0, 32'h00000000, 0});
    tbl.push_back('{0, 12'h010, 32'h0,        2'b10, 0, 0, 32'hDEADBEEF, 0});
    tbl.push_back('{1, 12'h013, 32'h12345680, 2'b00, 0, 0, 32'h00000000, 0});
    tbl.push_back('{0, 12'h013, 32'h0,        2'b00, 1, 0, 32'hFFFFFF80, 0});
    tbl.push_back('{0, 12'h013, 32'h0,        2'b00, 0, 0, 32'h00000080, 0});
    tbl.push_back('{0, 12'h012, 32'h0,        2'b01, 1, 0, 32'hFFFF80AD, 0});
    tbl.push_back('{0, 12'h010, 32'h0,        2'b10, 0, 0, 32'h80ADBEEF, 0});
    tbl.push_back('{0, 12'h010, 32'h0,        2'b01, 0, 0, 32'h0000BEEF, 0});
    tbl.push_back('{0, 12'h010, 32'h0,        2'b01, 1, 0, 32'hFFFFBEEF, 0});
    tbl.push_back('{1, 12'h012, 32'h11111111, 2'b10, 0, 0, 32'h00000000, 1});
    tbl.push_back('{0, 12'h010, 32'h0,        2'b10, 0, 0, 32'h80ADBEEF, 0});
    tbl.push_back('{0, 12'h010, 32'h0,        2'b11, 0, 0, 32'h00000000, 1});
    tbl.push_back('{1, 12'h011, 32'hAAAA5A5A, 2'b01, 0, 0, 32'h00000000, 1});
    tbl.push_back('{1, 12'h012, 32'hFFFF1234, 2'b01, 0, 0, 32'h00000000, 0});
    tbl.push_back('{0, 12'h010, 32'h0,        2'b10, 0, 5, 32'h1234BEEF, 0});
    tbl.push_back('{0, 12'h011, 32'h0,        2'b00, 1, 0, 32'hFFFFFFBE, 0});
    tbl.push_back('{0, 12'h012, 32'h0,        2'b00, 1, 0, 32'h00000034, 0});
    tbl.push_back('{0, 12'h013, 32'h0,        2'b01, 0, 0, 32'h00000000, 1});
    tbl.push_back('{1, 12'h010, 32'hABCDEF7F, 2'b00, 0, 0, 32'h00000000, 0});
    tbl.push_back('{0, 12'h010, 32'h0,        2'b10, 0, 2, 32'h1234BE7F, 0});
    tbl.push_back('{0, 12'h011, 32'h0,        2'b10, 0, 0, 32'h00000000, 1});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      chk("reset_outputs", {o_rdy, o_vld, o_err, 29'd0}, {3'b100, 29'd0});
      chk("reset_rdata", o_rdata, 32'd0);
    end

    // Directed table on the one-wait-state instance.
    foreach (tbl[i]) begin
      do_req(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].len, tbl[i].sg, tbl[i].hold, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_er});
    end

    // Randomized traffic against the byte-array model in a freshly written region.
    for (int k = 0; k < 16; k++) begin
      mrd = $urandom;
      model(0, 1'b1, 'h100 + 4*k, mrd, 2, 1'b0, rd, mer);
      do_req(0, 1'b1, 12'(12'h100 + 4*k), mrd, 2'b10, 1'b0, 0, rd, er);
    end
    for (int k = 0; k < 80; k++) begin
      bit          w, sg;
      logic [11:0] a;
      logic [31:0] wd;
      logic [1:0]  len;
      w = 1'($urandom); sg = 1'($urandom); a = 12'(12'h100 + $urandom_range(0, 63));
      wd = $urandom; len = 2'($urandom_range(0, 3));
      model(0, w, int'(a), wd, int'(len), sg, mrd, mer);
      do_req(0, w, a, wd, len, sg, $urandom_range(0, 2), rd, er);
      chk($sformatf("rnd%0d_rdata", k), rd, mrd);
      chk($sformatf("rnd%0d_err", k), {31'd0, er}, {31'd0, mer});
    end

    // Reset while a store sits in WAIT on the three-wait-state instance.
    do_req(1, 1'b1, 12'h020, 32'hCAFEF00D, 2'b10, 1'b0, 0, rd, er);
    do_req(1, 1'b0, 12'h020, 32'h0, 2'b10, 1'b0, 0, rd, er);
    chk("pre_reset_load", rd, 32'hCAFEF00D);
    sel = 1; req_write = 1'b1; req_addr = 12'h020; req_wdata = 32'h12345678;
    req_length = 2'b10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("in_wait", {30'd0, o_vld, o_rdy}, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_reset_outputs", {o_rdy, o_vld, o_err, 29'd0}, {3'b100, 29'd0});
    chk("post_reset_rdata", o_rdata, 32'd0);
    repeat (5) @(posedge clk);
    #1 chk("no_late_response", {31'd0, o_vld}, 32'd0);
    do_req(1, 1'b0, 12'h020, 32'h0, 2'b10, 1'b0, 0, rd, er);
    chk("dropped_store", rd, 32'hCAFEF00D);

    // Zero-wait-state stream with both valid and ready held high.
    for (int k = 0; k < 4; k++) begin
      mrd = $urandom;
      model(2, 1'b1, 'h040 + 4*k, mrd, 2, 1'b0, rd, mer);
      do_req(2, 1'b1, 12'(12'h040 + 4*k), mrd, 2'b10, 1'b0, 0, rd, er);
    end
    sa = '{12'h040, 12'h047, 12'h04A, 12'h04C};
    sl = '{2'b10, 2'b00, 2'b01, 2'b01};
    ss = '{1'b0, 1'b1, 1'b0, 1'b1};
    sel = 2; req_write = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = sa[k]; req_length = sl[k]; req_sign = ss[k];
      chk($sformatf("stream%0d_ready", k), {31'd0, o_rdy}, 32'd1);
      model(2, 1'b0, int'(sa[k]), 32'd0, int'(sl[k]), ss[k], mrd, mer);
      @(posedge clk); #1;
      chk($sformatf("stream%0d_valid", k), {31'd0, o_vld}, 32'd1);
      chk($sformatf("stream%0d_rdata", k), o_rdata, mrd);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("stream_end_idle", {30'd0, o_vld, o_rdy}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
